// File: rtl/input_debouncer_pkg.sv
// Shared definitions for the input debouncer.
// Holds the per-channel FSM state encoding and the default
// stability count and counter width used by input_debouncer.
package input_debouncer_pkg;

    // Gray-like encoding: STABLE_* states carry the output level in bit 1.
    typedef enum logic [1:0] {
        STABLE_LOW  = 2'b00,
        PEND_HIGH   = 2'b01,
        STABLE_HIGH = 2'b11,
        PEND_LOW    = 2'b10
    } deb_state_e;

    localparam int DEFAULT_STABLE_COUNT = 4;
    localparam int DEFAULT_CNT_WIDTH    = 16;

endpackage : input_debouncer_pkg

// File: rtl/debounce_channel.sv
// One debounced input channel.
// Two-flop synchroniser, stability counter and four-state FSM.
// The clean level changes only after the synchronised input has held
// the new value for STABLE_COUNT consecutive cycles; a one-cycle rise
// or fall strobe accompanies the first cycle of the new level.
//
// Ports:
//   clk     system clock, rising edge
//   rst     synchronous active-high reset
//   raw     asynchronous raw input
//   level   debounced level (registered)
//   rise    one-cycle strobe on level 0->1
//   fall    one-cycle strobe on level 1->0
module debounce_channel
    import input_debouncer_pkg::*;
#(
    parameter int STABLE_COUNT = DEFAULT_STABLE_COUNT,
    parameter int CNT_WIDTH    = DEFAULT_CNT_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    // Terminal count compared at full counter width.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_COUNT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic                 sync1_q;
    logic                 sync2_q;
    deb_state_e           state_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic                 level_q;
    logic                 rise_q;
    logic                 fall_q;

    // Counter never passes CNT_LAST, so the increment cannot wrap.
    assign cnt_d = cnt_q + CNT_ONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= STABLE_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            // sync1_q may go metastable; only sync2_q feeds the FSM.
            sync1_q <= raw;
            sync2_q <= sync1_q;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            case (state_q)
                STABLE_LOW: begin
                    if (sync2_q) begin
                        state_q <= PEND_HIGH;
                        cnt_q   <= '0;
                    end
                end
                PEND_HIGH: begin
                    if (!sync2_q) begin
                        // Reversal: drop the pending edge silently.
                        state_q <= STABLE_LOW;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= STABLE_HIGH;
                        cnt_q   <= '0;
                        level_q <= 1'b1;
                        rise_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                STABLE_HIGH: begin
                    if (!sync2_q) begin
                        state_q <= PEND_LOW;
                        cnt_q   <= '0;
                    end
                end
                PEND_LOW: begin
                    if (sync2_q) begin
                        state_q <= STABLE_HIGH;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= STABLE_LOW;
                        cnt_q   <= '0;
                        level_q <= 1'b0;
                        fall_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    state_q <= STABLE_LOW;
                    cnt_q   <= '0;
                    level_q <= 1'b0;
                end
            endcase
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule : debounce_channel

// File: rtl/input_debouncer.sv
// Two-channel synchroniser/debouncer for board-level switch inputs.
// Channels A and B are independent instances of debounce_channel.
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   raw_a, raw_b   asynchronous raw inputs
//   a, b           debounced levels (registered)
//   rise_a/fall_a  one-cycle edge strobes for a
//   rise_b/fall_b  one-cycle edge strobes for b
module input_debouncer
    import input_debouncer_pkg::*;
#(
    parameter int STABLE_COUNT = DEFAULT_STABLE_COUNT,
    parameter int CNT_WIDTH    = DEFAULT_CNT_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_a,
    input  logic raw_b,
    output logic a,
    output logic b,
    output logic rise_a,
    output logic fall_a,
    output logic rise_b,
    output logic fall_b
);

    // Index 0 is channel A, index 1 is channel B.
    logic [1:0] raw_vec;
    logic [1:0] level_vec;
    logic [1:0] rise_vec;
    logic [1:0] fall_vec;

    assign raw_vec = {raw_b, raw_a};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            debounce_channel #(
                .STABLE_COUNT (STABLE_COUNT),
                .CNT_WIDTH    (CNT_WIDTH)
            ) u_chan (
                .clk   (clk),
                .rst   (rst),
                .raw   (raw_vec[gi]),
                .level (level_vec[gi]),
                .rise  (rise_vec[gi]),
                .fall  (fall_vec[gi])
            );
        end
    endgenerate

    assign a      = level_vec[0];
    assign b      = level_vec[1];
    assign rise_a = rise_vec[0];
    assign fall_a = fall_vec[0];
    assign rise_b = rise_vec[1];
    assign fall_b = fall_vec[1];

endmodule : input_debouncer
